// File: rtl/adventure_grid_fsm_pkg.sv
// Shared types for the adventure grid game: game states, move directions
// and the one-hot press decoder used by the location FSM.
package adventure_pkg;

    typedef enum logic [1:0] {
        PLAY,
        WON,
        DEAD
    } game_state_t;

    typedef enum logic [2:0] {
        DIR_N,
        DIR_S,
        DIR_E,
        DIR_W,
        DIR_NONE
    } dir_t;

    // Bit order of the press vector is {W, E, S, N}; anything but exactly one bit is no move.
    function automatic dir_t dir_decode(input logic [3:0] press);
        dir_t dir;
        case (press)
            4'b0001: dir = DIR_N;
            4'b0010: dir = DIR_S;
            4'b0100: dir = DIR_E;
            4'b1000: dir = DIR_W;
            default: dir = DIR_NONE;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/adventure_grid_fsm_if.sv
// Button and status bundle between the board (master) and the grid FSM (slave).
interface adventure_grid_fsm_if #(
    parameter int GRID_W = 4,
    parameter int GRID_H = 4,
    parameter int MW     = 8
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    logic          N;
    logic          S;
    logic          E;
    logic          W;
    logic          D;
    logic          WIN;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          sword;
    logic [MW-1:0] moves;

    modport master (
        output N, S, E, W,
        input  D, WIN, pos_x, pos_y, sword, moves
    );

    modport slave (
        input  N, S, E, W,
        output D, WIN, pos_x, pos_y, sword, moves
    );

endinterface

// File: rtl/adventure_grid_fsm_button_edge.sv
// Rising-edge detector for the four direction buttons. The previous-level
// register tracks the buttons every cycle, including during reset.
module button_edge (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic [3:0] press
);

    logic [3:0] prev_q;
    logic [3:0] prev_d;

    always_comb begin
        prev_d = btn;
    end

    // Loading the live levels on reset keeps a button held through reset from reading as a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= btn;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign press = btn & ~prev_q;

endmodule

// File: rtl/adventure_grid_fsm.sv
// Parametrised room-grid location FSM: moves the player one room per button
// press, tracks the sword, counts moves and decides win/death on the dragon room.
module adventure_grid_fsm
    import adventure_pkg::*;
#(
    parameter int GRID_W    = 4,
    parameter int GRID_H    = 4,
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int SWORD_X   = 3,
    parameter int SWORD_Y   = 0,
    parameter int DRAGON_X  = 3,
    parameter int DRAGON_Y  = 3,
    parameter int MAX_MOVES = 0,
    parameter int MW        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    adventure_grid_fsm_if.slave  bus
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    localparam logic [XW-1:0] START_XV  = XW'(START_X);
    localparam logic [YW-1:0] START_YV  = YW'(START_Y);
    localparam logic [XW-1:0] SWORD_XV  = XW'(SWORD_X);
    localparam logic [YW-1:0] SWORD_YV  = YW'(SWORD_Y);
    localparam logic [XW-1:0] DRAGON_XV = XW'(DRAGON_X);
    localparam logic [YW-1:0] DRAGON_YV = YW'(DRAGON_Y);
    localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);
    localparam logic [MW-1:0] BUDGET    = MW'(MAX_MOVES);

    if (GRID_W < 2 || GRID_H < 2 ||
        START_X  < 0 || START_X  >= GRID_W || START_Y  < 0 || START_Y  >= GRID_H ||
        SWORD_X  < 0 || SWORD_X  >= GRID_W || SWORD_Y  < 0 || SWORD_Y  >= GRID_H ||
        DRAGON_X < 0 || DRAGON_X >= GRID_W || DRAGON_Y < 0 || DRAGON_Y >= GRID_H) begin : g_bad_room
        $error("adventure_grid_fsm: grid too small or room coordinate outside the grid");
    end

    if ((DRAGON_X == START_X && DRAGON_Y == START_Y) ||
        (DRAGON_X == SWORD_X && DRAGON_Y == SWORD_Y)) begin : g_bad_dragon
        $error("adventure_grid_fsm: dragon room must differ from the start and sword rooms");
    end

    function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
        return (&v) ? v : v + MW'(1);
    endfunction

    logic [3:0] press;
    dir_t       dir;

    button_edge u_button_edge (
        .clock (clock),
        .reset (reset),
        .btn   ({bus.W, bus.E, bus.S, bus.N}),
        .press (press)
    );

    assign dir = dir_decode(press);

    game_state_t   state_q, state_d;
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic          sword_q, sword_d;
    logic [MW-1:0] moves_q, moves_d;

    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          step_ok;
    logic [MW-1:0] moves_inc;

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        sword_d   = sword_q;
        moves_d   = moves_q;
        next_x    = pos_x_q;
        next_y    = pos_y_q;
        step_ok   = 1'b0;
        moves_inc = sat_inc(moves_q);

        // A step toward a wall leaves step_ok low, so the move is simply dropped.
        case (dir)
            DIR_N: if (pos_y_q != '0)    begin next_y = pos_y_q - YW'(1); step_ok = 1'b1; end
            DIR_S: if (pos_y_q != Y_MAX) begin next_y = pos_y_q + YW'(1); step_ok = 1'b1; end
            DIR_E: if (pos_x_q != X_MAX) begin next_x = pos_x_q + XW'(1); step_ok = 1'b1; end
            DIR_W: if (pos_x_q != '0)    begin next_x = pos_x_q - XW'(1); step_ok = 1'b1; end
            default: ;
        endcase

        if (state_q == PLAY && step_ok) begin
            pos_x_d = next_x;
            pos_y_d = next_y;
            moves_d = moves_inc;
            // Dragon outcome outranks the move budget, so a winning last move still wins.
            if (next_x == DRAGON_XV && next_y == DRAGON_YV) begin
                state_d = sword_q ? WON : DEAD;
            end else if (MAX_MOVES != 0 && moves_inc == BUDGET) begin
                state_d = DEAD;
            end else if (next_x == SWORD_XV && next_y == SWORD_YV) begin
                sword_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PLAY;
            pos_x_q <= START_XV;
            pos_y_q <= START_YV;
            sword_q <= 1'b0;
            moves_q <= '0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            sword_q <= sword_d;
            moves_q <= moves_d;
        end
    end

    assign bus.D     = (state_q == DEAD);
    assign bus.WIN   = (state_q == WON);
    assign bus.pos_x = pos_x_q;
    assign bus.pos_y = pos_y_q;
    assign bus.sword = sword_q;
    assign bus.moves = moves_q;

endmodule

// File: tb/tb_adventure_grid_fsm.sv
// Scoreboard bench: three grid FSMs (budget 0, 4, 6) share one button stream;
// a room-walk model predicts each outcome and a monitor compares on a strobe.
module tb_adventure_grid_fsm;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic       sword;
        logic [7:0] moves;
        logic       d;
        logic       win;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn   = 4'b0000;   // {W, E, S, N}
    logic       obs   = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int step_id  = 0;

    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];

    // Reference model state: status 0 = playing, 1 = won, 2 = dead.
    int m_x[3], m_y[3], m_sw[3], m_mv[3], m_st[3];
    int budget[3] = '{0, 4, 6};

    always #5 clock = ~clock;

    adventure_grid_fsm_if #(.GRID_W(4), .GRID_H(4), .MW(8)) bus0 ();
    adventure_grid_fsm_if #(.GRID_W(4), .GRID_H(4), .MW(8)) bus1 ();
    adventure_grid_fsm_if #(.GRID_W(4), .GRID_H(4), .MW(8)) bus2 ();

    assign bus0.N = btn[0]; assign bus0.S = btn[1]; assign bus0.E = btn[2]; assign bus0.W = btn[3];
    assign bus1.N = btn[0]; assign bus1.S = btn[1]; assign bus1.E = btn[2]; assign bus1.W = btn[3];
    assign bus2.N = btn[0]; assign bus2.S = btn[1]; assign bus2.E = btn[2]; assign bus2.W = btn[3];

    adventure_grid_fsm #(.MAX_MOVES(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    adventure_grid_fsm #(.MAX_MOVES(4)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    adventure_grid_fsm #(.MAX_MOVES(6)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

    function automatic obs_t model_obs(input int k);
        obs_t o;
        o.x     = 2'(m_x[k]);
        o.y     = 2'(m_y[k]);
        o.sword = (m_sw[k] != 0);
        o.moves = 8'(m_mv[k]);
        o.d     = (m_st[k] == 2);
        o.win   = (m_st[k] == 1);
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_x[k] = 0; m_y[k] = 0; m_sw[k] = 0; m_mv[k] = 0; m_st[k] = 0;
        end
    endtask

    task automatic model_press(input logic [3:0] mask);
        int dx, dy, nx, ny;
        if ($countones(mask) != 1) return;
        dx = mask[2] ? 1 : (mask[3] ? -1 : 0);
        dy = mask[1] ? 1 : (mask[0] ? -1 : 0);
        for (int k = 0; k < 3; k++) begin
            nx = m_x[k] + dx;
            ny = m_y[k] + dy;
            if (m_st[k] != 0 || nx < 0 || nx > 3 || ny < 0 || ny > 3) continue;
            m_x[k] = nx;
            m_y[k] = ny;
            if (m_mv[k] < 255) m_mv[k]++;
            if (nx == 3 && ny == 3)                         m_st[k] = (m_sw[k] != 0) ? 1 : 2;
            else if (budget[k] != 0 && m_mv[k] == budget[k]) m_st[k] = 2;
            else if (nx == 3 && ny == 0)                    m_sw[k] = 1;
        end
    endtask

    task automatic expect_now();
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
        q2.push_back(model_obs(2));
        step_id++;
        obs = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        obs = 1'b0;
    endtask

    // Button held for `hold` cycles then released for two; one rising edge at most.
    task automatic press_for(input logic [3:0] mask, input int hold);
        tick();
        btn = mask;
        for (int i = 0; i < hold; i++) tick();
        btn = 4'b0000;
        tick();
        tick();
        model_press(mask);
        expect_now();
    endtask

    task automatic press(input logic [3:0] mask);
        press_for(mask, 2);
    endtask

    task automatic do_reset(input logic [3:0] held);
        tick();
        btn   = held;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        btn = 4'b0000;
        tick();
        model_reset();
        expect_now();
    endtask

    task automatic check_one(input int k, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL step%0d dut%0d: got x=%0d y=%0d sword=%0b moves=%0d D=%0b WIN=%0b, want x=%0d y=%0d sword=%0b moves=%0d D=%0b WIN=%0b",
                     step_id, k, act.x, act.y, act.sword, act.moves, act.d, act.win,
                     exp.x, exp.y, exp.sword, exp.moves, exp.d, exp.win);
        end
    endtask

    always @(negedge clock) begin
        if (obs) begin
            if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty step%0d: got no expected entry, want one per dut", step_id);
            end else begin
                check_one(0, {bus0.pos_x, bus0.pos_y, bus0.sword, bus0.moves, bus0.D, bus0.WIN}, q0.pop_front());
                check_one(1, {bus1.pos_x, bus1.pos_y, bus1.sword, bus1.moves, bus1.D, bus1.WIN}, q1.pop_front());
                check_one(2, {bus2.pos_x, bus2.pos_y, bus2.sword, bus2.moves, bus2.D, bus2.WIN}, q2.pop_front());
            end
        end
    end

    localparam logic [3:0] BN = 4'b0001, BS = 4'b0010, BE = 4'b0100, BW = 4'b1000;

    initial begin
        logic [3:0] m;
        int r, a, b;

        do_reset(4'b0000);

        // Walls at the start corner.
        press(BN); press(BW);

        // Sword then dragon; the budgeted instances hit their limits on the way.
        press(BE); press(BE); press(BE);
        press(BS); press(BS); press(BS);
        press(BE); press(BN);

        // Dragon without sword.
        do_reset(4'b0000);
        press(BS); press(BS); press(BS);
        press(BE); press(BE); press(BE);
        press(BE); press(BN);

        // Long hold is one move; simultaneous rise is none.
        do_reset(4'b0000);
        press_for(BE, 6);
        press(BE | BS);

        // Budget exhaustion by shuttling.
        do_reset(4'b0000);
        press(BE); press(BW); press(BE); press(BW);

        // Win, then reset with N held through deassert.
        do_reset(4'b0000);
        press(BE); press(BE); press(BE);
        press(BS); press(BS); press(BS);
        do_reset(BN);
        press(BN);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 80) begin
                m = 4'b0001 << $urandom_range(0, 3);
                press(m);
            end else if (r < 88) begin
                a = $urandom_range(0, 3);
                b = (a + $urandom_range(1, 3)) % 4;
                m = (4'b0001 << a) | (4'b0001 << b);
                if ($urandom_range(0, 1) == 1) m = m | 4'(1 << $urandom_range(0, 3));
                press(m);
            end else if (r < 94) begin
                m = 4'b0001 << $urandom_range(0, 3);
                press_for(m, $urandom_range(3, 7));
            end else begin
                do_reset(4'(4'b0001 << $urandom_range(0, 3)));
            end
        end

        tick();
        tick();
        n_checks++;
        if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d/%0d/%0d left, want 0/0/0", q0.size(), q1.size(), q2.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/adventure_grid_fsm.md
Name: adventure_grid_fsm

Overview:
- Parametrised successor to the fixed-map location FSM used by the adventure game top level (`design_1_wrapper`).
- Player moves on a GRID_W x GRID_H room grid using N/S/E/W buttons, with one move per button press.
- Sword room sets an item flag. Entering the dragon room wins with the sword and dies without it.
- An optional move budget kills the player when exhausted. D and WIN drive the board LEDs as before.

Parameters:
- GRID_W, 4, rooms in x (east positive), >=2
- GRID_H, 4, rooms in y (south positive), >=2
- START_X / START_Y, 0 / 0, reset room
- SWORD_X / SWORD_Y, 3 / 0, sword room
- DRAGON_X / DRAGON_Y, 3 / 3, dragon room; must differ from the start and sword rooms
- MAX_MOVES, 0, move budget; 0 = unlimited
- MW, 8, move counter width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- N  in  1  north button, level (already debounced)
- S  in  1  south button
- E  in  1  east button
- W  in  1  west button
- D  out  1  player dead (sticky)
- WIN  out  1  player won (sticky)
- pos_x  out  $clog2(GRID_W)  current x
- pos_y  out  $clog2(GRID_H)  current y
- sword  out  1  sword held
- moves  out  MW  accepted-move count, saturating

Behaviour:
- One clock. Reset is synchronous and active-high: ports `clock` and `reset`; polarity and synchronicity fixed.
- Reset values (visible after the reset edge):
  - pos = (START_X, START_Y); sword = 0; moves = 0; D = 0; WIN = 0; state = PLAY.
  - Edge-detect prev registers load the current button levels, so a button held through reset never causes a move.
- Press detection: press_x = X & ~prev_x; prev_x <= X every cycle.
- Valid press: exactly one press_x in a cycle. Zero presses or two or more simultaneous presses = no action.
- Latency: a valid press seen at edge t updates pos/sword/moves/D/WIN at edge t. All are registered outputs, visible one cycle after the button rises.
- Wall rule: a move that would leave the grid is blocked. pos is unchanged, moves is unchanged, the state is unchanged.
- Accepted move: pos steps by one room (N: y-1, S: y+1, E: x+1, W: x-1). moves increments, saturating at 2^MW-1.
- States:
  - PLAY: the only state that accepts moves.
  - WON: WIN=1, all input ignored until reset.
  - DEAD: D=1, all input ignored until reset.
- Transitions from PLAY on an accepted move into room R, evaluated in priority order:
  1. R == dragon and (sword or R == sword room; the parameter check forbids the latter) -> WON.
  2. R == dragon, no sword -> DEAD.
  3. MAX_MOVES != 0 and new moves == MAX_MOVES -> DEAD.
  4. R == sword room -> sword <= 1, stay in PLAY.
- A winning move on the last budgeted move is WON, not DEAD.
- sword stays 1 after pickup and re-entering the sword room has no effect. No item drop.
- D and WIN are never both 1. Both are sticky until reset.
- Reset mid-game from any state returns every output to its reset value at that edge. Reset overrides a press in the same cycle.
- Elaboration check: $error if any room coordinate is out of grid, or if DRAGON equals START or SWORD.

Decomposition:
- Package `adventure_pkg`:
  - typedef enum {PLAY, WON, DEAD} game_state_t.
  - typedef enum {DIR_N, DIR_S, DIR_E, DIR_W, DIR_NONE} dir_t.
  - Function `dir_decode(press[3:0])`: returns DIR_NONE unless exactly one bit is set.
- One sub-module `button_edge`: registers a 4-bit prev, outputs a 4-bit press vector, and preloads prev on reset. The FSM, position datapath and counter stay in the top.

Test Plan (default parameters unless stated; each press = button high 2 cycles then low 2 cycles):
1. Reset, press N, then W -> both blocked; pos=(0,0), moves=0, D=WIN=0.
2. E,E,E -> pos=(3,0), sword=1, moves=3. Then S,S,S -> pos=(3,3), WIN=1, D=0, moves=6. Further presses change nothing.
3. From reset S,S,S,E,E,E (no sword) -> D=1 on the 6th move, pos=(3,3), sword=0, WIN=0. Subsequent E/N ignored.
4. Hold E for 6 cycles -> exactly one move, pos=(1,0). Raise E and S in the same cycle -> no move, moves unchanged.
5. MAX_MOVES=4: E,W,E,W -> D=1 on the 4th move, moves=4. Separate run with MAX_MOVES=6: route E,E,E,S,S,S -> WIN=1 (win beats budget).
6. Reach WON, assert reset for 1 cycle while holding N through deassert -> all outputs back to reset values. Releasing N causes no move; the next N press is blocked by the wall.
